// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and line-level constants
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_START_LVL = 1'b0;
    localparam logic UART_STOP_LVL  = 1'b1;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered storage, head on rdata, occupancy count and full/empty flags
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic do_push, do_pop;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-buffered 8N1 UART transmitter driving txd from the CPU uartWrite byte stream
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          uartWriteReq,
    input  logic [7:0]                    uartWriteData,
    output logic                          uartWriteReady,
    output logic                          txd,
    output logic                          txBusy,
    output logic [$clog2(FIFO_DEPTH):0]   fifoCount
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    uart_state_t state;
    logic [BW-1:0] baud;
    logic [$clog2(UART_DATA_BITS)-1:0] bit_idx;
    logic [UART_DATA_BITS-1:0] shifter, head;
    logic full, empty, baud_end, pop;
    assign baud_end       = baud == BW'(CLKS_PER_BIT - 1);
    assign pop            = !empty && (state == IDLE || (state == STOP && baud_end));
    assign uartWriteReady = !full;
    assign txBusy         = state != IDLE || !empty;
    sync_fifo #(.WIDTH(UART_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (uartWriteReq),
        .pop   (pop),
        .wdata (uartWriteData),
        .rdata (head),
        .count (fifoCount),
        .full  (full),
        .empty (empty)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            txd     <= UART_STOP_LVL;
            baud    <= '0;
            bit_idx <= '0;
            shifter <= '0;
        end else begin
            case (state)
                IDLE: begin
                    baud <= '0;
                    if (!empty) begin
                        shifter <= head;
                        txd     <= UART_START_LVL;
                        state   <= START;
                    end
                end
                START: begin
                    baud <= baud_end ? '0 : baud + 1'b1;
                    if (baud_end) begin
                        txd     <= shifter[0];
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    baud <= baud_end ? '0 : baud + 1'b1;
                    if (baud_end && bit_idx == 3'(UART_DATA_BITS - 1)) begin
                        txd   <= UART_STOP_LVL;
                        state <= STOP;
                    end else if (baud_end) begin
                        shifter <= shifter >> 1;
                        txd     <= shifter[1];
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
                default: begin
                    baud <= baud_end ? '0 : baud + 1'b1;
                    if (baud_end && !empty) begin
                        shifter <= head;
                        txd     <= UART_START_LVL;
                        state   <= START;
                    end else if (baud_end) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: directed self-checking bench with a serial-line monitor and expected-byte queue
module tb_uart_tx_buffered;
    logic clk = 0, reset = 1, req = 0;
    logic [7:0] data = 0;
    logic ready, txd, busy;
    logic [2:0] cnt;
    int n_cmp = 0, n_err = 0, cyc = 0;
    logic [7:0] exp_q[$];
    int st_q[$];
    uart_tx_buffered #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .uartWriteReq   (req),
        .uartWriteData  (data),
        .uartWriteReady (ready),
        .txd            (txd),
        .txBusy         (busy),
        .fifoCount      (cnt)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", busy, 0);
        repeat (2) @(negedge clk);
        check("pending_frames", exp_q.size(), 0);
    endtask
    initial begin
        logic [9:0] bits;
        logic stable, abort;
        int t0;
        forever begin
            @(negedge clk);
            if (!reset && txd === 1'b0) begin
                t0 = cyc;
                stable = 1;
                abort = 0;
                bits = '0;
                for (int k = 0; k < 40; k++) begin
                    if (k > 0) @(negedge clk);
                    if (reset) begin
                        abort = 1;
                        break;
                    end
                    if (k % 4 == 0) bits[k/4] = txd;
                    else if (txd !== bits[k/4]) stable = 0;
                end
                if (!abort) begin
                    st_q.push_back(t0);
                    check("start_bit", bits[0], 0);
                    check("stop_bit", bits[9], 1);
                    check("bit_stable", stable, 1);
                    check("frame_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) check("rx_byte", bits[8:1], exp_q.pop_front());
                end
            end
        end
    end
    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
    initial begin
        logic [7:0] six [6];
        six = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        req = 1;
        data = 8'h55;
        repeat (2) @(negedge clk);
        check("rst_txd", txd, 1);
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_count", cnt, 0);
        reset = 0;
        req = 0;
        repeat (3) @(negedge clk);
        check("post_rst_count", cnt, 0);
        check("post_rst_txd", txd, 1);
        // single frame 0xA5 with exact latency
        exp_q.push_back(8'hA5);
        req = 1;
        data = 8'hA5;
        @(negedge clk);
        req = 0;
        check("a5_txd_before", txd, 1);
        check("a5_count_queued", cnt, 1);
        check("a5_busy", busy, 1);
        @(negedge clk);
        check("a5_txd_fall", txd, 0);
        check("a5_count_popped", cnt, 0);
        repeat (39) @(negedge clk);
        check("a5_busy_late", busy, 1);
        @(negedge clk);
        check("a5_busy_drop", busy, 0);
        check("a5_txd_idle", txd, 1);
        wait_idle(20);
        // back-to-back 0x00, 0xFF
        st_q.delete();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        req = 1;
        data = 8'h00;
        @(negedge clk);
        data = 8'hFF;
        @(negedge clk);
        req = 0;
        wait_idle(200);
        check("b2b_frames", st_q.size(), 2);
        if (st_q.size() == 2) check("b2b_gap", st_q[1] - st_q[0], 40);
        // overflow: 6 bytes offered, 5 accepted
        for (int i = 0; i < 5; i++) exp_q.push_back(six[i]);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) begin
                check("ovf_ready", ready, 0);
                check("ovf_count", cnt, 4);
            end
            req = 1;
            data = six[i];
            @(negedge clk);
        end
        req = 0;
        check("ovf_count_after", cnt, 4);
        wait_idle(400);
        // reset during data bit 3 of 0x3C with two bytes queued
        req = 1;
        data = 8'h3C;
        @(negedge clk);
        data = 8'h11;
        @(negedge clk);
        data = 8'h22;
        @(negedge clk);
        req = 0;
        repeat (16) @(negedge clk);
        check("mid_txd_bit3", txd, 1);
        check("mid_count", cnt, 2);
        reset = 1;
        @(negedge clk);
        check("mid_rst_txd", txd, 1);
        check("mid_rst_count", cnt, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", ready, 1);
        reset = 0;
        repeat (6) @(negedge clk);
        check("mid_rst_quiet", txd, 1);
        exp_q.push_back(8'h81);
        req = 1;
        data = 8'h81;
        @(negedge clk);
        req = 0;
        wait_idle(100);
        // push concurrent with IDLE pop
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'hC3);
        req = 1;
        data = 8'h5A;
        @(negedge clk);
        check("pp_count_first", cnt, 1);
        data = 8'hC3;
        @(negedge clk);
        req = 0;
        check("pp_count_same", cnt, 1);
        check("pp_txd_start", txd, 0);
        wait_idle(200);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
